// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
// Contents: scanner FSM states, matrix dimensions, 2-bit row/column index type,
//           and a lowest-set-row priority helper.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    // Lowest-numbered active row wins when several rows are low together.
    function automatic idx_t lowest_row(input logic [NUM_ROWS-1:0] rows);
        idx_t idx;
        idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) begin
                idx = idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pin and decoder-side signal bundle
// Signals: row_in (row pins, active-low), col_out (column drive, active-low one-cold),
//          key_row/key_col (accepted key index), key_pulse (press strobe),
//          key_held (accepted key still down).
// master: the scanner; slave: pins/decoder side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row_in;
    logic [NUM_COLS-1:0] col_out;
    idx_t                key_row;
    idx_t                key_col;
    logic                key_pulse;
    logic                key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_row,
        output key_col,
        output key_pulse,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_row,
        input  key_col,
        input  key_pulse,
        input  key_held
    );

endinterface

// File: rtl/keypad_row_sync.sv
// rtl/keypad_row_sync.sv - two-flop synchronizer for the keypad row pins
// Ports: clk, rst (async active-high), row_in (raw pins), row_sync (synchronized pins).
// Resets to all-ones, the idle pulled-up level, so no key is seen out of reset.
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_ROWS-1:0] row_sync
);

    logic [NUM_ROWS-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= '1;
            row_sync <= '1;
        end else begin
            meta     <= row_in;
            row_sync <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce
// Ports: clk, rst (async active-high), kp (keypad_scanner_if.master):
//        row_in in, col_out/key_row/key_col/key_pulse/key_held out.
// Parameters: SCAN_TICKS (cycles per column, >=4), DEBOUNCE_CYCLES (stable cycles, >=2).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 27000,
    parameter int DEBOUNCE_CYCLES = 270000
)
(
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ROWS-1:0] synced;
    logic [NUM_ROWS-1:0] rows_s;

    state_t        state;
    idx_t          col_idx;
    idx_t          cap_row;
    idx_t          cap_col;
    idx_t          key_row_q;
    idx_t          key_col_q;
    logic          key_pulse_q;
    logic          key_held_q;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] deb_cnt;

    keypad_row_sync u_row_sync (
        .clk      (clk),
        .rst      (rst),
        .row_in   (kp.row_in),
        .row_sync (synced)
    );

    // Rows are pulled up; a pressed key in the driven column pulls its row low.
    assign rows_s = ~synced;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SCAN;
            col_idx     <= '0;
            cap_row     <= '0;
            cap_col     <= '0;
            key_row_q   <= '0;
            key_col_q   <= '0;
            key_pulse_q <= 1'b0;
            key_held_q  <= 1'b0;
            tick_cnt    <= '0;
            deb_cnt     <= '0;
        end else begin
            key_pulse_q <= 1'b0;
            case (state)
                SCAN: begin
                    // Earlier ticks let the new column settle through the synchronizer.
                    if (tick_cnt == TICK_LAST) begin
                        if (rows_s != '0) begin
                            cap_row <= lowest_row(rows_s);
                            cap_col <= col_idx;
                            deb_cnt <= '0;
                            state   <= DEB_PRESS;
                        end else begin
                            col_idx  <= col_idx + 2'd1;
                            tick_cnt <= '0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                DEB_PRESS: begin
                    if (!rows_s[cap_row]) begin
                        // Bounce: resume scanning at the column after the captured one.
                        col_idx  <= cap_col + 2'd1;
                        tick_cnt <= '0;
                        state    <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_row_q   <= cap_row;
                        key_col_q   <= cap_col;
                        key_pulse_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        state       <= PRESSED;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    // Only the captured row matters; other keys are ignored.
                    if (!rows_s[cap_row]) begin
                        deb_cnt <= '0;
                        state   <= DEB_RELEASE;
                    end
                end

                DEB_RELEASE: begin
                    if (rows_s[cap_row]) begin
                        state <= PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held_q <= 1'b0;
                        col_idx    <= cap_col + 2'd1;
                        tick_cnt   <= '0;
                        state      <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

    // col_idx only advances in SCAN, so the drive stays frozen on the captured column.
    assign kp.col_out   = ~(4'b0001 << col_idx);
    assign kp.key_row   = key_row_q;
    assign kp.key_col   = key_col_q;
    assign kp.key_pulse = key_pulse_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int ST  = 4;
    localparam int DEB = 8;
    localparam int LAT_MIN = DEB + 3;
    localparam int LAT_MAX = 4 * ST + DEB + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_TICKS      (ST),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Physical keypad: a closed switch (r,c) pulls row r low while column c is driven low.
    logic [3:0][3:0] keys = '0;
    logic [3:0]      row_v;

    always_comb begin
        row_v = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if ((keys[r] & ~kp.col_out) != 4'h0) row_v[r] = 1'b0;
        end
    end
    assign kp.row_in = row_v;

    typedef struct {
        int t;
        int r;
        int c;
    } pulse_t;

    pulse_t pulse_q[$];
    int     wide_cnt   = 0;
    logic   prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (kp.key_pulse) begin
            pulse_q.push_back('{cyc, int'(kp.key_row), int'(kp.key_col)});
            if (prev_pulse) wide_cnt++;
        end
        prev_pulse = kp.key_pulse;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] col_code(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        keys[r][c] = 1'b1;
    endtask

    task automatic release_key(input int r, input int c);
        keys[r][c] = 1'b0;
    endtask

    // Return at the first negedge of a fresh drive window on column c.
    task automatic wait_col(input int c);
        int  n;
        bit  ok;
        ok = 1'b0;
        for (n = 0; n < 40; n++) begin
            if (kp.col_out != col_code(c)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            ok = 1'b0;
            for (n = 0; n < 40; n++) begin
                if (kp.col_out == col_code(c)) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
        end
        if (!ok) chk("wait_col_timeout", int'(kp.col_out), int'(col_code(c)));
    endtask

    task automatic expect_pulse(input string tag, input int r, input int c, input int t0);
        int lat;
        chk({tag, "_pulse_count"}, pulse_q.size(), 1);
        if (pulse_q.size() > 0) begin
            lat = pulse_q[0].t - t0;
            chk({tag, "_key_row"}, pulse_q[0].r, r);
            chk({tag, "_key_col"}, pulse_q[0].c, c);
            chk({tag, "_latency_in_window"}, int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        end
    endtask

    // Called at the negedge the key is released; key_held must fall DEB+3 edges later.
    task automatic wait_release(input string tag);
        int t_rel;
        t_rel = cyc;
        for (int n = 0; n < 40 && kp.key_held; n++) @(negedge clk);
        chk({tag, "_release_latency"}, cyc - t_rel, DEB + 3);
    endtask

    initial begin
        int t0;
        int lows;
        int r;
        int c;
        int r2;
        int c2;
        int hold;

        // Reset state
        step(3);
        chk("rst_col_out", int'(kp.col_out), 4'b1110);
        chk("rst_key_held", int'(kp.key_held), 0);
        chk("rst_key_pulse", int'(kp.key_pulse), 0);
        chk("rst_key_row", int'(kp.key_row), 0);
        chk("rst_key_col", int'(kp.key_col), 0);

        // Idle scan: column advances every ST cycles
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("idle_col_out", int'(kp.col_out), int'(col_code((k / ST) % 4)));
        end
        step(84);
        chk("idle_no_pulse", pulse_q.size(), 0);

        // Clean press (2,1)
        pulse_q.delete();
        wait_col(1);
        t0 = cyc;
        press(2, 1);
        step(50);
        expect_pulse("clean", 2, 1, t0);
        chk("clean_held", int'(kp.key_held), 1);
        release_key(2, 1);
        wait_release("clean");
        step(5);
        chk("clean_single_pulse", pulse_q.size(), 1);
        chk("clean_row_kept", int'(kp.key_row), 2);

        // Bounce on (0,3)
        pulse_q.delete();
        wait_col(3);
        press(0, 3);
        step(5);
        release_key(0, 3);
        step(12);
        chk("bounce_no_pulse", pulse_q.size(), 0);
        chk("bounce_not_held", int'(kp.key_held), 0);
        wait_col(3);
        t0 = cyc;
        press(0, 3);
        step(20);
        expect_pulse("bounce", 0, 3, t0);
        release_key(0, 3);
        wait_release("bounce");

        // Release glitch on (1,0)
        pulse_q.delete();
        wait_col(0);
        t0 = cyc;
        press(1, 0);
        step(20);
        expect_pulse("glitch", 1, 0, t0);
        release_key(1, 0);
        lows = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (!kp.key_held) lows++;
        end
        press(1, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!kp.key_held) lows++;
        end
        chk("glitch_held_low_cycles", lows, 0);
        chk("glitch_no_second_pulse", pulse_q.size(), 1);
        release_key(1, 0);
        wait_release("glitch");

        // Two rows in column 2, then row 3 again while row 1 held
        pulse_q.delete();
        wait_col(2);
        t0 = cyc;
        press(1, 2);
        press(3, 2);
        step(20);
        expect_pulse("multi", 1, 2, t0);
        release_key(3, 2);
        step(5);
        press(3, 2);
        step(30);
        chk("multi_no_pulse_row3", pulse_q.size(), 1);
        release_key(3, 2);
        step(5);
        release_key(1, 2);
        wait_release("multi");
        step(10);
        chk("multi_total_pulses", pulse_q.size(), 1);

        // Reset while PRESSED on (2,3)
        pulse_q.delete();
        wait_col(3);
        t0 = cyc;
        press(2, 3);
        step(20);
        expect_pulse("prerst", 2, 3, t0);
        rst = 1'b1;
        #1;
        chk("midrst_col_out", int'(kp.col_out), 4'b1110);
        chk("midrst_key_held", int'(kp.key_held), 0);
        chk("midrst_key_row", int'(kp.key_row), 0);
        chk("midrst_key_col", int'(kp.key_col), 0);
        step(2);
        pulse_q.delete();
        rst = 1'b0;
        t0 = cyc;
        step(40);
        expect_pulse("postrst", 2, 3, t0);
        release_key(2, 3);
        wait_release("postrst");

        // Randomized presses; optional unrelated key while the first is accepted
        for (int it = 0; it < 12; it++) begin
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            hold = $urandom_range(30, 60);
            step($urandom_range(0, 10));
            pulse_q.delete();
            t0 = cyc;
            press(r, c);
            step(LAT_MAX + 1);
            if ($urandom_range(0, 1) == 1) begin
                r2 = $urandom_range(0, 3);
                c2 = $urandom_range(0, 3);
                if (r2 == r && c2 == c) r2 = (r + 1) % 4;
                press(r2, c2);
                step(5);
                release_key(r2, c2);
            end
            step(hold - LAT_MAX);
            expect_pulse("rand", r, c, t0);
            chk("rand_held", int'(kp.key_held), 1);
            release_key(r, c);
            wait_release("rand");
            step(2);
            chk("rand_single_pulse", pulse_q.size(), 1);
        end

        chk("pulse_width_violations", wide_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
        $fatal(1);
    end

endmodule
